kf_spike_fanout: RTL and testbench
==================================

// Module: kf_spike_fanout
// PURPOSE
//  Per-neuron destination fan-out stage between kf_snn_core spike output and kf_noc_router local input.
//  - Each output spike (post_id, payload) is looked up in a neuron pointer table, {base, count}.
//  - It is then expanded into `count` spike_flit_t flits, one per destination entry in a destination list.
//  - Replaces the fixed payload-encoded destination scheme with a programmable per-neuron routing table.
// PARAMETERS
//  N_NEURONS    KF_NEURONS_PER_TILE  pointer-table depth (one entry per local neuron)
//  N_DEST       256                  destination-list depth; power of two
//  FANOUT_BITS  4                    width of count field; max fan-out 2**FANOUT_BITS-1
//  ADDR_BITS    8                    cfg_addr width; >= clog2(max(N_NEURONS,N_DEST))
// PORTS
//  clk             in   1                  tile clock
//  rst_n           in   1                  asynchronous reset, active low
//  spike_in_valid  in   1                  spike from core
//  spike_in_ready  out  1                  stage can accept spike
//  spike_in_post_id in  KF_NEURON_ID_BITS  firing neuron
//  spike_in_payload in  8                  spike payload
//  flit_out_valid  out  1                  flit to router local port
//  flit_out_ready  in   1                  router accepts flit
//  flit_out        out  $bits(spike_flit_t) {dest_x, dest_y, neuron_id, payload}
//  cfg_we          in   1                  table write strobe
//  cfg_tbl         in   1                  0 = pointer table, 1 = destination list
//  cfg_addr        in   ADDR_BITS          entry index
//  cfg_wdata       in   32                 entry data (see CONFIGURATION)
//  busy            out  1                  high when not IDLE
//  drop_count      out  16                 spikes dropped because count==0; saturating
//  flit_count      out  32                 flits handed off; wraps
// BEHAVIOUR
//  - Reset, asynchronous: the following are cleared.
//    - State goes to IDLE.
//    - flit_out_valid=0, flit_out=0, busy=0, drop_count=0, flit_count=0.
//    - spike_in_ready=1 after reset release.
//    - Table contents are cleared: all counts 0, all destinations 0.
//  - FSM IDLE / EMIT. spike_in_ready = (state==IDLE).
//  - IDLE, spike_in_valid=1:
//    - Accept the spike.
//    - Read the pointer entry combinationally.
//    - Latch post_id, payload, base, count.
//  - Accept with count!=0:
//    - Go to EMIT.
//    - Register the first flit from dest[base].
//    - flit_out_valid=1 in the next cycle (latency 1).
//  - Accept with count==0: drop the spike, drop_count+1 (saturates at 16'hFFFF), stay IDLE.
//  - EMIT:
//    - flit_out is held stable while valid & !ready.
//    - On each handshake, flit_count+1 and remaining-1.
//    - If flits remain, the next flit, dest[(base+i) mod N_DEST], is loaded on the same edge; no bubble.
//    - On the last handshake: go to IDLE, flit_out_valid=0, spike_in_ready=1 the next cycle.
//  - Throughput: count flits in count cycles with ready held high, then 1 idle cycle before the next accept.
//  - Flit fields: neuron_id = latched post_id; payload = latched payload; dest_x/dest_y from the destination entry.
//  - Destination index arithmetic is modulo N_DEST; a list may wrap past N_DEST-1 to 0.
//  - Pointer entries are sampled at acceptance only. Rewriting a neuron's pointer mid-EMIT does not affect the spike in flight.
//  - Destination entries are read when each flit is loaded. A write in the same cycle as the load returns the old value (read-before-write).
//  - Reset mid-EMIT: the in-flight spike is lost and flit_out_valid drops asynchronously.
// CONFIGURATION
//  - cfg_tbl=0: ptr[cfg_addr] <= {count=cfg_wdata[8+FANOUT_BITS-1:8], base=cfg_wdata[7:0]}.
//  - cfg_tbl=1: dest[cfg_addr] <= {dest_y=cfg_wdata[15:8], dest_x=cfg_wdata[7:0]}.
//  - Writes with cfg_addr beyond table depth are ignored.
//  - Writes are accepted in any state; single-cycle, no ready.
//  - Optional feature, macro KF_FANOUT_LEGACY_ROUTE_EN.
//    - Defined: a count==0 spike is not dropped. It emits exactly one flit with dest_x={4'b0,payload[7:4]} and dest_y={4'b0,payload[3:0]}. drop_count stays 0.
//    - Undefined: drop behaviour as above.
// STRUCTURE
//  - kf_pkg additions:
//    - kf_fanout_ptr_t {base[7:0], count[KF_FANOUT_BITS-1:0]}
//    - kf_fanout_dest_t {dest_y[7:0], dest_x[7:0]}
//    - KF_FANOUT_DESTS=256, KF_FANOUT_BITS=4
//  - Sub-module kf_fanout_table: one write port, one combinational read port, reset-cleared register file.
//    - Instantiated twice: pointer table and destination list.
//  - The FSM, flit register and counters live in the top.
// TESTING
//  1. ptr[5]={base=10,count=3}, dest[10..12]=(1,0),(2,3),(0,1); spike id5 payload 8'hA5, ready=1.
//     -> 3 flits on consecutive cycles, first one cycle after accept, each neuron_id=5, payload=A5.
//     -> flit_count=3, spike_in_ready low for 3 cycles.
//  2. Same setup, ready=0 for 4 cycles mid-list -> flit 2 held bit-stable, no duplicate or skipped dest, order preserved.
//  3. ptr[7]={base=255,count=2}, dest[255]=(3,3), dest[0]=(1,1) -> flits to (3,3) then (1,1) (wrap).
//  4. ptr[9].count=0, spike id9 payload 8'h21.
//     -> macro undefined: no flit, drop_count=1.
//     -> macro defined: one flit dest (2,1), drop_count=0.
//  5. Assert rst_n during EMIT of a 4-flit spike after flit 1.
//     -> flit_out_valid=0 immediately, counters 0, busy=0, tables cleared.
//     -> next spike to any neuron is dropped.
//  6. Write ptr[5]={base=20,count=1} in the cycle after accepting id5 (old count 3).
//     -> 3 flits from old base; next id5 spike emits 1 flit from dest[20].

Source files
------------

// File: rtl/kf_spike_fanout_pkg.sv
// Shared types and sizes for the spike fan-out stage.
// KF_FANOUT_LEGACY_ROUTE_EN (see kf_spike_fanout) is not used in this file.
package kf_spike_fanout_pkg;

  localparam int KF_NEURONS_PER_TILE = 64;
  localparam int KF_NEURON_ID_BITS   = 6;
  localparam int KF_FANOUT_DESTS     = 256;
  localparam int KF_FANOUT_BITS      = 4;

  typedef struct packed {
    logic [7:0]                   dest_x;
    logic [7:0]                   dest_y;
    logic [KF_NEURON_ID_BITS-1:0] neuron_id;
    logic [7:0]                   payload;
  } spike_flit_t;

  typedef struct packed {
    logic [7:0]                base;
    logic [KF_FANOUT_BITS-1:0] count;
  } kf_fanout_ptr_t;

  typedef struct packed {
    logic [7:0] dest_y;
    logic [7:0] dest_x;
  } kf_fanout_dest_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } fanout_state_e;

  function automatic spike_flit_t mk_flit(kf_fanout_dest_t d,
                                          logic [KF_NEURON_ID_BITS-1:0] id,
                                          logic [7:0] pl);
    spike_flit_t f;
    f.dest_x    = d.dest_x;
    f.dest_y    = d.dest_y;
    f.neuron_id = id;
    f.payload   = pl;
    return f;
  endfunction

endpackage

// File: rtl/kf_spike_fanout_table.sv
// Reset-cleared register file: one write port, one combinational read port.
// Out-of-range writes are dropped; out-of-range reads return zero.
module kf_fanout_table #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        w_hit;
  logic                        r_hit;

  assign w_hit = we && ({1'b0, waddr} < (AW+1)'(DEPTH));
  assign r_hit = {1'b0, raddr} < (AW+1)'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (w_hit) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  // Read sees the pre-write contents in a write cycle.
  assign rdata = r_hit ? mem[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/kf_spike_fanout.sv
// Expands each core spike into per-destination flits via a pointer table and destination list.
// Define KF_FANOUT_LEGACY_ROUTE_EN to route count==0 spikes by payload instead of dropping them.
module kf_spike_fanout
  import kf_spike_fanout_pkg::*;
#(
  parameter int N_NEURONS   = KF_NEURONS_PER_TILE,
  parameter int N_DEST      = KF_FANOUT_DESTS,
  parameter int FANOUT_BITS = KF_FANOUT_BITS,
  parameter int ADDR_BITS   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spike_in_valid,
  output logic                         spike_in_ready,
  input  logic [KF_NEURON_ID_BITS-1:0] spike_in_post_id,
  input  logic [7:0]                   spike_in_payload,
  output logic                         flit_out_valid,
  input  logic                         flit_out_ready,
  output logic [$bits(spike_flit_t)-1:0] flit_out,
  input  logic                         cfg_we,
  input  logic                         cfg_tbl,
  input  logic [ADDR_BITS-1:0]         cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  output logic                         busy,
  output logic [15:0]                  drop_count,
  output logic [31:0]                  flit_count
);

  localparam int PW    = 8 + FANOUT_BITS;
  localparam int IDX_W = $clog2(N_DEST);

`ifdef KF_FANOUT_LEGACY_ROUTE_EN
  localparam bit LEGACY_EN = 1'b1;
`else
  localparam bit LEGACY_EN = 1'b0;
`endif

  fanout_state_e              state_q, state_d;
  logic [PW-1:0]              ptr_rdata;
  logic [FANOUT_BITS-1:0]     ptr_count;
  logic [7:0]                 ptr_base;
  kf_fanout_dest_t            dest_rdata;
  logic [IDX_W-1:0]           dest_idx;
  logic [IDX_W-1:0]           next_idx_q;
  logic [FANOUT_BITS-1:0]     rem_q;
  logic [KF_NEURON_ID_BITS-1:0] id_q;
  logic [7:0]                 pl_q;
  spike_flit_t                flit_q;
  spike_flit_t                legacy_flit;
  logic                       accept;
  logic                       handshake;
  logic                       zero_cnt;
  logic                       unused_cfg;

  assign unused_cfg = &{1'b0, cfg_wdata[31:16]};

  kf_fanout_table #(.DEPTH(N_NEURONS), .WIDTH(PW), .AW(ADDR_BITS)) u_ptr_tbl (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we & ~cfg_tbl),
    .waddr (cfg_addr),
    .wdata (cfg_wdata[PW-1:0]),
    .raddr (ADDR_BITS'(spike_in_post_id)),
    .rdata (ptr_rdata)
  );

  kf_fanout_table #(.DEPTH(N_DEST), .WIDTH(16), .AW(ADDR_BITS)) u_dest_tbl (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we & cfg_tbl),
    .waddr (cfg_addr),
    .wdata (cfg_wdata[15:0]),
    .raddr (ADDR_BITS'(dest_idx)),
    .rdata (dest_rdata)
  );

  assign ptr_count = ptr_rdata[PW-1:8];
  assign ptr_base  = ptr_rdata[7:0];
  assign zero_cnt  = (ptr_count == '0);

  // In IDLE the list read is aimed at the incoming spike's base; in EMIT at the next entry.
  assign dest_idx = (state_q == ST_IDLE) ? IDX_W'(ptr_base) : next_idx_q;

  assign accept    = (state_q == ST_IDLE) && spike_in_valid;
  assign handshake = (state_q == ST_EMIT) && flit_out_ready;

  always_comb begin
    legacy_flit           = '0;
    legacy_flit.dest_x    = {4'b0, spike_in_payload[7:4]};
    legacy_flit.dest_y    = {4'b0, spike_in_payload[3:0]};
    legacy_flit.neuron_id = spike_in_post_id;
    legacy_flit.payload   = spike_in_payload;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (spike_in_valid && (!zero_cnt || LEGACY_EN)) state_d = ST_EMIT;
      ST_EMIT: if (flit_out_ready && rem_q == FANOUT_BITS'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      next_idx_q <= '0;
      rem_q      <= '0;
      id_q       <= '0;
      pl_q       <= '0;
      flit_q     <= '0;
      drop_count <= '0;
      flit_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q <= spike_in_post_id;
        pl_q <= spike_in_payload;
        if (!zero_cnt) begin
          rem_q      <= ptr_count;
          next_idx_q <= dest_idx + IDX_W'(1);
          flit_q     <= mk_flit(dest_rdata, spike_in_post_id, spike_in_payload);
        end else if (LEGACY_EN) begin
          rem_q  <= FANOUT_BITS'(1);
          flit_q <= legacy_flit;
        end else if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
      // Next flit is loaded on the accepting edge so back-to-back flits have no bubble.
      if (handshake) begin
        flit_count <= flit_count + 32'd1;
        rem_q      <= rem_q - FANOUT_BITS'(1);
        if (rem_q != FANOUT_BITS'(1)) begin
          flit_q     <= mk_flit(dest_rdata, id_q, pl_q);
          next_idx_q <= next_idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign spike_in_ready = (state_q == ST_IDLE);
  assign flit_out_valid = (state_q == ST_EMIT);
  assign busy           = (state_q != ST_IDLE);
  assign flit_out       = flit_q;

endmodule

// File: tb/tb_kf_spike_fanout.sv
// Directed bench for kf_spike_fanout; expectations follow KF_FANOUT_LEGACY_ROUTE_EN when defined.
module tb_kf_spike_fanout;
  import kf_spike_fanout_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         spike_in_valid = 1'b0;
  logic                         spike_in_ready;
  logic [KF_NEURON_ID_BITS-1:0] spike_in_post_id = '0;
  logic [7:0]                   spike_in_payload = '0;
  logic                         flit_out_valid;
  logic                         flit_out_ready = 1'b0;
  logic [$bits(spike_flit_t)-1:0] flit_out;
  logic                         cfg_we = 1'b0;
  logic                         cfg_tbl = 1'b0;
  logic [7:0]                   cfg_addr = '0;
  logic [31:0]                  cfg_wdata = '0;
  logic                         busy;
  logic [15:0]                  drop_count;
  logic [31:0]                  flit_count;

  int total = 0;
  int bad   = 0;
  int fc    = 0;

  always #5 clk = ~clk;

  kf_spike_fanout dut (
    .clk(clk), .rst_n(rst_n),
    .spike_in_valid(spike_in_valid), .spike_in_ready(spike_in_ready),
    .spike_in_post_id(spike_in_post_id), .spike_in_payload(spike_in_payload),
    .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready), .flit_out(flit_out),
    .cfg_we(cfg_we), .cfg_tbl(cfg_tbl), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .drop_count(drop_count), .flit_count(flit_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fl(input logic [7:0] x, input logic [7:0] y,
                                     input logic [KF_NEURON_ID_BITS-1:0] id,
                                     input logic [7:0] pl);
    spike_flit_t f;
    f.dest_x = x; f.dest_y = y; f.neuron_id = id; f.payload = pl;
    return 64'(f);
  endfunction

  task automatic cfg(input logic tbl, input logic [7:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_tbl = tbl; cfg_addr = addr; cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic spike(input logic [KF_NEURON_ID_BITS-1:0] id, input logic [7:0] pl);
    spike_in_valid = 1'b1; spike_in_post_id = id; spike_in_payload = pl;
    @(negedge clk);
    spike_in_valid = 1'b0;
  endtask

  // Checks the flit currently presented, then advances one cycle.
  task automatic exp_flit(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [KF_NEURON_ID_BITS-1:0] id, input logic [7:0] pl);
    chk({tag, "_valid"}, 64'(flit_out_valid), 64'd1);
    chk({tag, "_rdy_low"}, 64'(spike_in_ready), 64'd0);
    chk({tag, "_flit"}, 64'(flit_out), fl(x, y, id, pl));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_valid", 64'(flit_out_valid), 64'd0);
    chk("rst_flit", 64'(flit_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_fcnt", 64'(flit_count), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(spike_in_ready), 64'd1);

    // Test 1: three flits back to back
    cfg(1'b0, 8'd5, 32'h0000_030A);
    cfg(1'b1, 8'd10, 32'h0000_0001);
    cfg(1'b1, 8'd11, 32'h0000_0302);
    cfg(1'b1, 8'd12, 32'h0000_0100);
    flit_out_ready = 1'b1;
    spike(6'd5, 8'hA5);
    chk("t1_busy", 64'(busy), 64'd1);
    exp_flit("t1_f1", 8'd1, 8'd0, 6'd5, 8'hA5);
    exp_flit("t1_f2", 8'd2, 8'd3, 6'd5, 8'hA5);
    exp_flit("t1_f3", 8'd0, 8'd1, 6'd5, 8'hA5);
    fc += 3;
    chk("t1_done_valid", 64'(flit_out_valid), 64'd0);
    chk("t1_done_ready", 64'(spike_in_ready), 64'd1);
    chk("t1_fcnt", 64'(flit_count), 64'(fc));

    // Test 2: backpressure on flit 2
    spike(6'd5, 8'hA5);
    exp_flit("t2_f1", 8'd1, 8'd0, 6'd5, 8'hA5);
    flit_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", 64'(flit_out_valid), 64'd1);
      chk("t2_hold_flit", 64'(flit_out), fl(8'd2, 8'd3, 6'd5, 8'hA5));
      @(negedge clk);
    end
    flit_out_ready = 1'b1;
    exp_flit("t2_f2", 8'd2, 8'd3, 6'd5, 8'hA5);
    exp_flit("t2_f3", 8'd0, 8'd1, 6'd5, 8'hA5);
    fc += 3;
    chk("t2_done_valid", 64'(flit_out_valid), 64'd0);
    chk("t2_fcnt", 64'(flit_count), 64'(fc));

    // Test 3: list wraps past the last destination entry
    cfg(1'b0, 8'd7, 32'h0000_02FF);
    cfg(1'b1, 8'd255, 32'h0000_0303);
    cfg(1'b1, 8'd0, 32'h0000_0101);
    spike(6'd7, 8'h3C);
    exp_flit("t3_f1", 8'd3, 8'd3, 6'd7, 8'h3C);
    exp_flit("t3_f2", 8'd1, 8'd1, 6'd7, 8'h3C);
    fc += 2;
    chk("t3_done_valid", 64'(flit_out_valid), 64'd0);
    chk("t3_fcnt", 64'(flit_count), 64'(fc));

    // Test 4: count==0 neuron
    spike(6'd9, 8'h21);
`ifdef KF_FANOUT_LEGACY_ROUTE_EN
    exp_flit("t4_legacy", 8'd2, 8'd1, 6'd9, 8'h21);
    fc += 1;
    chk("t4_drop", 64'(drop_count), 64'd0);
`else
    chk("t4_drop", 64'(drop_count), 64'd1);
    chk("t4_ready", 64'(spike_in_ready), 64'd1);
`endif
    chk("t4_valid", 64'(flit_out_valid), 64'd0);
    chk("t4_fcnt", 64'(flit_count), 64'(fc));

    // Test 6: pointer rewrite while the spike is in flight
    cfg(1'b1, 8'd20, 32'h0000_0605);
    spike(6'd5, 8'h77);
    cfg_we = 1'b1; cfg_tbl = 1'b0; cfg_addr = 8'd5; cfg_wdata = 32'h0000_0114;
    exp_flit("t6_f1", 8'd1, 8'd0, 6'd5, 8'h77);
    cfg_we = 1'b0;
    exp_flit("t6_f2", 8'd2, 8'd3, 6'd5, 8'h77);
    exp_flit("t6_f3", 8'd0, 8'd1, 6'd5, 8'h77);
    chk("t6_old_done", 64'(flit_out_valid), 64'd0);
    spike(6'd5, 8'h78);
    exp_flit("t6_new", 8'd5, 8'd6, 6'd5, 8'h78);
    fc += 4;
    chk("t6_new_done", 64'(flit_out_valid), 64'd0);
    chk("t6_fcnt", 64'(flit_count), 64'(fc));

    // Test 5: reset in the middle of a 4-flit spike
    cfg(1'b0, 8'd3, 32'h0000_041E);
    cfg(1'b1, 8'd30, 32'h0000_0202);
    cfg(1'b1, 8'd31, 32'h0000_0404);
    spike(6'd3, 8'h11);
    exp_flit("t5_f1", 8'd2, 8'd2, 6'd3, 8'h11);
    chk("t5_pre_valid", 64'(flit_out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(flit_out_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_fcnt", 64'(flit_count), 64'd0);
    chk("t5_rst_drop", 64'(drop_count), 64'd0);
    chk("t5_rst_flit", 64'(flit_out), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready", 64'(spike_in_ready), 64'd1);
    spike(6'd5, 8'h21);
`ifdef KF_FANOUT_LEGACY_ROUTE_EN
    exp_flit("t5_legacy", 8'd2, 8'd1, 6'd5, 8'h21);
    chk("t5_after_drop", 64'(drop_count), 64'd0);
    chk("t5_after_fcnt", 64'(flit_count), 64'd1);
`else
    chk("t5_after_valid", 64'(flit_out_valid), 64'd0);
    chk("t5_after_drop", 64'(drop_count), 64'd1);
    chk("t5_after_fcnt", 64'(flit_count), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
